echo_delay: RTL and testbench
=============================

ECHO_DELAY -- requirements
Module: echo_delay

Interface
REQ-001 SHALL have parameter A_WIDTH, default 9, buffer address width; buffer depth = 2^A_WIDTH samples.
REQ-002 SHALL have parameter D_WIDTH, default 8, sample width, signed two's complement.
REQ-003 SHALL have parameter G_WIDTH, default 8, feedback gain width, unsigned fraction gain/2^G_WIDTH.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  enables acceptance of new samples.
REQ-007 in_valid  input  1  sample strobe.
REQ-008 in_sample  input  D_WIDTH  input sample.
REQ-009 delay  input  A_WIDTH  delay in samples, 0..2^A_WIDTH-1.
REQ-010 mode  input  1  0 = pure delay, 1 = feedback echo.
REQ-011 fb_gain  input  G_WIDTH  feedback gain.
REQ-012 out_sample  output  D_WIDTH  processed sample, registered.
REQ-013 out_valid  output  1  one-cycle pulse, out_sample valid.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL contain an internal 2^A_WIDTH x D_WIDTH circular buffer with registered (one-cycle) read, single write port.
REQ-016 SHALL implement FSM IDLE -> READ -> CALC -> IDLE; busy = (state != IDLE).
REQ-017 Sample accepted at an edge only when state = IDLE, en = 1, in_valid = 1; in_valid otherwise ignored (no queueing).
REQ-018 On acceptance: capture in_sample, delay, mode, fb_gain; read address = (wr_ptr - delay) mod 2^A_WIDTH; go READ.
REQ-019 READ -> CALC unconditionally; CALC -> IDLE unconditionally; max throughput one sample per 3 cycles.
REQ-020 Accepted at edge N: out_sample and out_valid = 1 updated at edge N+2, out_valid high exactly one cycle.
REQ-021 Delayed value d = buffer read data, forced to 0 when captured delay > fill (unwritten locations never reach output).
REQ-022 Captured delay = 0: d = captured in_sample (bypass), buffer read ignored.
REQ-023 mode 0: out_sample = d; value written = in_sample.
REQ-024 mode 1: fb = (d * fb_gain) arithmetic-shifted right G_WIDTH; sum = in_sample + fb at full width; out_sample = sum saturated to D_WIDTH signed range; value written = out_sample.
REQ-025 Write at CALC edge to address wr_ptr; wr_ptr then increments mod 2^A_WIDTH (wrap 2^A_WIDTH-1 -> 0).
REQ-026 fill counter (A_WIDTH+1 bits) increments per write, saturates at 2^A_WIDTH.
REQ-027 Changes to delay/mode/fb_gain/en while busy SHALL NOT affect the transaction in progress; en low mid-transaction lets it complete.
REQ-028 out_sample holds its last value between out_valid pulses.

Reset
REQ-029 rst SHALL asynchronously force state IDLE, wr_ptr 0, fill 0, out_sample 0, out_valid 0, busy 0.
REQ-030 rst during READ/CALC SHALL abort the transaction: no buffer write, no out_valid.
REQ-031 Buffer contents are not reset; REQ-021 masks stale data.

Verification (A_WIDTH=4, D_WIDTH=8, G_WIDTH=8)
REQ-032 Reset, mode 0, delay 3, samples 10,20,30,40,50 -> out_sample 0,0,0,10,20, each out_valid two edges after acceptance.
REQ-033 Mode 0, delay 0, sample 25 -> out_sample 25; mode 1, delay 0, gain 128, sample 40 -> 60.
REQ-034 Reset, mode 1, delay 1, gain 128, samples 100,0,0,0 -> out_sample 100,50,25,12.
REQ-035 Mode 1, delay 1, gain 255, samples 100,100 -> 100 then 127 (saturated); samples -100,-100 -> -100 then -128.
REQ-036 Mode 0, delay 15, 20 samples valued 0..19 -> outputs 0 for samples 0..15 (sample 0 yields 0 either way), then 1,2,3,4; wr_ptr wraps 15 -> 0 without error.
REQ-037 in_valid held high with en 1 -> accepts every 3rd edge, busy high 2 cycles per sample; rst pulsed during CALC -> no out_valid, busy 0, next sample treated as first after reset (output 0 for delay > 0).

Source files
------------

// File: rtl/echo_delay.sv
// ---------------------------------------------------------------------------
// echo_delay
//   Single-channel delay/echo processor built around a circular sample buffer.
//   Each accepted sample walks through a three-state FSM:
//     IDLE -> READ (buffer read issued) -> CALC (result registered, buffer
//     written) -> IDLE.
//   mode 0 is a pure delay line. mode 1 adds a scaled copy of the delayed
//   sample back onto the input and stores the saturated result, which gives
//   a decaying echo.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   en          enables acceptance of new samples
//   in_valid    sample strobe; only honoured while idle (no queueing)
//   in_sample   signed input sample
//   delay       delay in samples (0 = bypass)
//   mode        0 = pure delay, 1 = feedback echo
//   fb_gain     unsigned feedback gain, value fb_gain / 2^G_WIDTH
//   out_sample  registered result; holds its value between out_valid pulses
//   out_valid   one-cycle pulse, two edges after acceptance
//   busy        high while a transaction is in flight
//
// Handshake: a sample is taken at a rising edge where busy = 0, en = 1 and
// in_valid = 1. There is no back-pressure; a strobe that arrives while busy
// or with en low is dropped. out_valid pulses for exactly one cycle.
// ---------------------------------------------------------------------------
module echo_delay #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8,
  parameter int G_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] in_sample,
  input  logic [A_WIDTH-1:0] delay,
  input  logic               mode,
  input  logic [G_WIDTH-1:0] fb_gain,
  output logic [D_WIDTH-1:0] out_sample,
  output logic               out_valid,
  output logic               busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;

  localparam int DEPTH = 1 << A_WIDTH;
  localparam int PW    = D_WIDTH + G_WIDTH + 1;

  localparam logic [A_WIDTH:0] FILL_MAX = {1'b1, {A_WIDTH{1'b0}}};
  localparam logic signed [D_WIDTH+1:0] SUM_MAX = {3'b000, {(D_WIDTH-1){1'b1}}};
  localparam logic signed [D_WIDTH+1:0] SUM_MIN = {3'b111, {(D_WIDTH-1){1'b0}}};

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic [1:0]                state;
  logic [A_WIDTH-1:0]        wr_ptr;
  logic [A_WIDTH-1:0]        rd_addr;
  logic [A_WIDTH:0]          fill;
  logic signed [D_WIDTH-1:0] rd_data;

  // Transaction context captured at acceptance so that input changes while
  // busy cannot disturb the sample in flight.
  logic signed [D_WIDTH-1:0] cap_sample;
  logic                      cap_mode;
  logic [G_WIDTH-1:0]        cap_gain;
  logic                      cap_bypass;  // delay was 0
  logic                      cap_mask;    // delay reaches past written data

  logic accept;
  assign accept = (state == S_IDLE) && en && in_valid;
  assign busy   = (state != S_IDLE);

  // -------------------------------------------------------------------------
  // Datapath (evaluated during CALC)
  // -------------------------------------------------------------------------
  logic signed [D_WIDTH-1:0] d_val;
  logic signed [PW-1:0]      d_ext;
  logic signed [PW-1:0]      g_ext;
  logic signed [PW-1:0]      prod;
  logic signed [PW-1:0]      prod_shift;
  logic signed [D_WIDTH:0]   fb;
  logic signed [D_WIDTH+1:0] sum;
  logic [D_WIDTH-1:0]        sat_val;
  logic [D_WIDTH-1:0]        result;
  logic [D_WIDTH-1:0]        wr_data;

  always_comb begin
    d_val = rd_data;
    if (cap_bypass) begin
      d_val = cap_sample;
    end else if (cap_mask) begin
      d_val = '0;
    end
    d_ext = {{(G_WIDTH+1){d_val[D_WIDTH-1]}}, d_val};
    g_ext = {{(D_WIDTH+1){1'b0}}, cap_gain};
    prod  = d_ext * g_ext;
    // |d * gain| / 2^G_WIDTH is bounded by |d|, so D_WIDTH+1 bits hold fb.
    prod_shift = prod >>> G_WIDTH;
    fb         = prod_shift[D_WIDTH:0];
    sum = {fb[D_WIDTH], fb} + {{2{cap_sample[D_WIDTH-1]}}, cap_sample};
    if (sum > SUM_MAX) begin
      sat_val = {1'b0, {(D_WIDTH-1){1'b1}}};
    end else if (sum < SUM_MIN) begin
      sat_val = {1'b1, {(D_WIDTH-1){1'b0}}};
    end else begin
      sat_val = sum[D_WIDTH-1:0];
    end
    result  = cap_mode ? sat_val : d_val;
    wr_data = cap_mode ? sat_val : cap_sample;
  end

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      fill       <= '0;
      out_sample <= '0;
      out_valid  <= 1'b0;
      rd_addr    <= '0;
      cap_sample <= '0;
      cap_mode   <= 1'b0;
      cap_gain   <= '0;
      cap_bypass <= 1'b0;
      cap_mask   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_sample <= in_sample;
            cap_mode   <= mode;
            cap_gain   <= fb_gain;
            cap_bypass <= (delay == '0);
            cap_mask   <= ({1'b0, delay} > fill);
            rd_addr    <= wr_ptr - delay;
            state      <= S_READ;
          end
        end
        S_READ: begin
          state <= S_CALC;
        end
        S_CALC: begin
          out_sample <= result;
          out_valid  <= 1'b1;
          wr_ptr     <= wr_ptr + 1'b1;
          if (fill != FILL_MAX) begin
            fill <= fill + 1'b1;
          end
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Sample buffer: one write port, registered read. Not reset; stale words
  // are hidden by the fill comparison. The rst term keeps a reset that lands
  // on the CALC edge from committing the aborted write.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((state == S_CALC) && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_echo_delay.sv
// ---------------------------------------------------------------------------
// tb_echo_delay
//   Directed bench for echo_delay with A_WIDTH=4, D_WIDTH=8, G_WIDTH=8.
//   Expected outputs are pushed into exp_q when a sample is driven and popped
//   when out_valid is seen. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_echo_delay;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int GW = 8;

  logic          clk;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [DW-1:0] in_sample;
  logic [AW-1:0] delay;
  logic          mode;
  logic [GW-1:0] fb_gain;
  logic [DW-1:0] out_sample;
  logic          out_valid;
  logic          busy;

  logic [DW-1:0] exp_q[$];

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  echo_delay #(.A_WIDTH(AW), .D_WIDTH(DW), .G_WIDTH(GW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .delay      (delay),
    .mode       (mode),
    .fb_gain    (fb_gain),
    .out_sample (out_sample),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  // clock / reset ------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking -----------------------------------------------------------------
  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drivers --------------------------------------------------------------------
  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sample", $signed(out_sample), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one sample, scrambles the control inputs while the transaction is
  // in flight, then waits (bounded) for out_valid and scores the result.
  task automatic send(input string tag, input logic signed [DW-1:0] s,
                      input logic [AW-1:0] dl, input logic m,
                      input logic [GW-1:0] g, input logic signed [DW-1:0] e);
    int  cyc;
    bit  seen;
    logic [DW-1:0] exp_v;
    logic [DW-1:0] held;
    @(negedge clk);
    en        = 1'b1;
    in_valid  = 1'b1;
    in_sample = s;
    delay     = dl;
    mode      = m;
    fb_gain   = g;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    en        = 1'($urandom_range(0, 1));
    delay     = AW'($urandom_range(0, 15));
    mode      = 1'($urandom_range(0, 1));
    fb_gain   = GW'($urandom_range(0, 255));
    in_sample = DW'($urandom_range(0, 255));
    cyc  = 0;
    seen = 0;
    while (cyc < 6 && !seen) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen = 1;
    end
    check({tag, "_latency"}, cyc, 3);
    exp_v = exp_q.pop_front();
    if (seen) begin
      check(tag, $signed(out_sample), $signed(exp_v));
      check({tag, "_busy_done"}, busy, 0);
      held = out_sample;
      @(negedge clk);
      check({tag, "_pulse"}, out_valid, 0);
      check({tag, "_hold"}, out_sample, held);
    end
  endtask

  // stimulus -----------------------------------------------------------------
  initial begin
    int outs;
    rst       = 1'b1;
    en        = 1'b0;
    in_valid  = 1'b0;
    in_sample = '0;
    delay     = '0;
    mode      = 1'b0;
    fb_gain   = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // pure delay of 3
    send("d3_s10", 8'sd10, 4'd3, 1'b0, 8'd0, 8'sd0);
    send("d3_s20", 8'sd20, 4'd3, 1'b0, 8'd0, 8'sd0);
    send("d3_s30", 8'sd30, 4'd3, 1'b0, 8'd0, 8'sd0);
    send("d3_s40", 8'sd40, 4'd3, 1'b0, 8'd0, 8'sd10);
    send("d3_s50", 8'sd50, 4'd3, 1'b0, 8'd0, 8'sd20);

    // bypass
    send("byp_m0", 8'sd25, 4'd0, 1'b0, 8'd0,   8'sd25);
    send("byp_m1", 8'sd40, 4'd0, 1'b1, 8'd128, 8'sd60);

    // decaying echo
    do_reset();
    send("echo_0", 8'sd100, 4'd1, 1'b1, 8'd128, 8'sd100);
    send("echo_1", 8'sd0,   4'd1, 1'b1, 8'd128, 8'sd50);
    send("echo_2", 8'sd0,   4'd1, 1'b1, 8'd128, 8'sd25);
    send("echo_3", 8'sd0,   4'd1, 1'b1, 8'd128, 8'sd12);

    // saturation
    do_reset();
    send("sat_p0", 8'sd100, 4'd1, 1'b1, 8'd255, 8'sd100);
    send("sat_p1", 8'sd100, 4'd1, 1'b1, 8'd255, 8'sd127);
    do_reset();
    send("sat_n0", -8'sd100, 4'd1, 1'b1, 8'd255, -8'sd100);
    send("sat_n1", -8'sd100, 4'd1, 1'b1, 8'd255, -8'sd128);

    // maximum delay and pointer wrap
    do_reset();
    for (int k = 0; k < 20; k++) begin
      send($sformatf("wrap_%0d", k), DW'(k), 4'd15, 1'b0, 8'd0,
           (k <= 15) ? 8'sd0 : DW'(k - 15));
    end

    // strobe ignored while en is low
    @(negedge clk);
    en        = 1'b0;
    in_valid  = 1'b1;
    in_sample = 8'sd77;
    delay     = 4'd0;
    mode      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("en_low_busy_%0d", i), busy, 0);
      check($sformatf("en_low_ov_%0d", i), out_valid, 0);
    end
    in_valid = 1'b0;

    // in_valid held high: one acceptance every third edge
    do_reset();
    en        = 1'b1;
    in_valid  = 1'b1;
    in_sample = 8'sd7;
    delay     = 4'd0;
    mode      = 1'b0;
    outs      = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("held_busy_%0d", i), busy, (i % 3 == 2) ? 0 : 1);
      check($sformatf("held_ov_%0d", i), out_valid, (i % 3 == 2) ? 1 : 0);
      if (out_valid) begin
        outs++;
        check($sformatf("held_val_%0d", i), $signed(out_sample), 7);
      end
    end
    check("held_count", outs, 3);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // reset during CALC aborts the transaction
    @(negedge clk);
    en        = 1'b1;
    in_valid  = 1'b1;
    in_sample = 8'sd55;
    delay     = 4'd0;
    mode      = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("abort_read_busy", busy, 1);
    @(posedge clk);
    #1;
    check("abort_calc_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ov", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_no_ov_%0d", i), out_valid, 0);
      check($sformatf("abort_idle_%0d", i), busy, 0);
    end
    send("post_abort_0", 8'sd9,  4'd1, 1'b0, 8'd0, 8'sd0);
    send("post_abort_1", 8'sd11, 4'd1, 1'b0, 8'd0, 8'sd9);

    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
